// File: rtl/conv_pkg.sv
// Types shared by the CONV instruction generator and its consumers: FSM states,
// the latched configuration and the per-pixel instruction record.
package conv_pkg;

  localparam int BYTE2WORD_SHIFT = 2;
  localparam int PKG_DATA_W      = 32;
  localparam int PKG_FRAM_AW     = 12;
  localparam int PKG_KRAM_AW     = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_PREP  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } instgen_state_e;

  typedef struct packed {
    logic [PKG_FRAM_AW-1:0] feature_baseaddr;
    logic [PKG_KRAM_AW-1:0] kernel_baseaddr;
    logic [PKG_FRAM_AW-1:0] wb_baseaddr;
    logic [PKG_DATA_W-1:0]  tile_chout;
    logic [PKG_DATA_W-1:0]  feature_chin;
    logic [PKG_DATA_W-1:0]  feature_width;
    logic [PKG_DATA_W-1:0]  feature_height;
    logic [PKG_DATA_W-1:0]  kernel_sizeh;
    logic [PKG_DATA_W-1:0]  kernel_sizew;
    logic                   has_bias;
    logic                   has_relu;
  } inst_t;

  typedef struct packed {
    logic [PKG_FRAM_AW-1:0] fbase;
    logic [PKG_KRAM_AW-1:0] kbase;
    logic [PKG_FRAM_AW-1:0] wbase;
    logic [PKG_DATA_W-1:0]  width;
    logic [PKG_DATA_W-1:0]  height;
    logic [PKG_DATA_W-1:0]  chin;
    logic [PKG_DATA_W-1:0]  chout;
    logic [PKG_DATA_W-1:0]  ksw;
    logic [PKG_DATA_W-1:0]  ksh;
    logic [PKG_DATA_W-1:0]  sw;
    logic [PKG_DATA_W-1:0]  sh;
    logic                   has_bias;
    logic                   has_relu;
  } cfg_t;

  // A VALID conv needs non-zero strides/dims and a kernel that fits the map.
  function automatic logic cfg_is_bad(input cfg_t c);
    return (c.sw == '0) || (c.sh == '0) || (c.ksw == '0) || (c.ksh == '0) ||
           (c.chin == '0) || (c.chout == '0) ||
           (c.ksw > c.width) || (c.ksh > c.height);
  endfunction

endpackage

// File: rtl/conv_pos_walker.sv
// Output-position walker: steps ox/oy across the map, then advances the chout
// tile. The nxt_* outputs are the values the counters take on this cycle.
module conv_pos_walker
  import conv_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAM_AW   = 12,
  parameter int KRAM_AW   = 12,
  parameter int COUT_TILE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               step,
  input  logic [DATA_W-1:0]  width,
  input  logic [DATA_W-1:0]  height,
  input  logic [DATA_W-1:0]  ksw,
  input  logic [DATA_W-1:0]  ksh,
  input  logic [DATA_W-1:0]  sw,
  input  logic [DATA_W-1:0]  sh,
  input  logic [DATA_W-1:0]  chout,
  input  logic [FRAM_AW-1:0] row_step,
  input  logic [KRAM_AW-1:0] ktile_step,
  output logic [DATA_W-1:0]  nxt_ox,
  output logic [FRAM_AW-1:0] nxt_row_base,
  output logic [KRAM_AW-1:0] nxt_kbase_off,
  output logic [FRAM_AW-1:0] nxt_wb_cnt,
  output logic [DATA_W-1:0]  nxt_tile_chout,
  output logic               last_step
);

  localparam int XW = DATA_W + 2;

  logic [DATA_W-1:0]  ox_q, ox_d, oy_q, oy_d, t_q, t_d, rem_q, rem_d;
  logic [FRAM_AW-1:0] row_base_q, row_base_d, wb_cnt_q, wb_cnt_d;
  logic [KRAM_AW-1:0] kbase_off_q, kbase_off_d;
  logic               col_wrap, row_wrap, last_tile;

  // Extra headroom bits so the end-of-window sums never overflow.
  assign col_wrap  = (XW'(ox_q) + XW'(sw) + XW'(ksw)) > XW'(width);
  assign row_wrap  = (XW'(oy_q) + XW'(sh) + XW'(ksh)) > XW'(height);
  assign last_tile = rem_q <= DATA_W'(COUT_TILE);
  assign last_step = step && col_wrap && row_wrap && last_tile;

  always_comb begin
    ox_d        = ox_q;
    oy_d        = oy_q;
    t_d         = t_q;
    rem_d       = rem_q;
    row_base_d  = row_base_q;
    wb_cnt_d    = wb_cnt_q;
    kbase_off_d = kbase_off_q;
    if (clear) begin
      ox_d        = '0;
      oy_d        = '0;
      t_d         = '0;
      rem_d       = chout;
      row_base_d  = '0;
      wb_cnt_d    = '0;
      kbase_off_d = '0;
    end else if (step) begin
      wb_cnt_d = wb_cnt_q + 1'b1;
      if (!col_wrap) begin
        ox_d = ox_q + sw;
      end else begin
        ox_d = '0;
        if (!row_wrap) begin
          oy_d       = oy_q + sh;
          row_base_d = row_base_q + row_step;
        end else begin
          // Remaining-channel count doubles as the tile counter: no divider.
          oy_d        = '0;
          row_base_d  = '0;
          t_d         = t_q + 1'b1;
          kbase_off_d = kbase_off_q + ktile_step;
          rem_d       = rem_q - DATA_W'(COUT_TILE);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox_q        <= '0;
      oy_q        <= '0;
      t_q         <= '0;
      rem_q       <= '0;
      row_base_q  <= '0;
      wb_cnt_q    <= '0;
      kbase_off_q <= '0;
    end else begin
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      t_q         <= t_d;
      rem_q       <= rem_d;
      row_base_q  <= row_base_d;
      wb_cnt_q    <= wb_cnt_d;
      kbase_off_q <= kbase_off_d;
    end
  end

  assign nxt_ox         = ox_d;
  assign nxt_row_base   = row_base_d;
  assign nxt_kbase_off  = kbase_off_d;
  assign nxt_wb_cnt     = wb_cnt_d;
  assign nxt_tile_chout = (rem_d > DATA_W'(COUT_TILE)) ? DATA_W'(COUT_TILE) : rem_d;

endmodule

// File: rtl/conv_tile_instgen.sv
// CONV instruction generator: latches a CSR config, validates it, then issues
// one registered instruction per output pixel per chout tile.
module conv_tile_instgen
  import conv_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int FRAM_AW   = 12,
  parameter int KRAM_AW   = 12,
  parameter int COUT_TILE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csrcmd_valid,
  output logic               instgen_ready,
  input  logic [ADDR_W-1:0]  feature_baseaddr,
  input  logic [ADDR_W-1:0]  kernel_baseaddr,
  input  logic [ADDR_W-1:0]  wb_baseaddr,
  input  logic [DATA_W-1:0]  feature_width,
  input  logic [DATA_W-1:0]  feature_height,
  input  logic [DATA_W-1:0]  feature_chin,
  input  logic [DATA_W-1:0]  feature_chout,
  input  logic [DATA_W-1:0]  kernel_sizew,
  input  logic [DATA_W-1:0]  kernel_sizeh,
  input  logic [DATA_W-1:0]  stride_w,
  input  logic [DATA_W-1:0]  stride_h,
  input  logic               has_bias,
  input  logic               has_relu,
  input  logic               abort,
  output logic               inst_valid,
  input  logic               decoder_ready,
  output logic [FRAM_AW-1:0] stride_feature_baseaddr,
  output logic [KRAM_AW-1:0] stride_kernel_baseaddr,
  output logic [FRAM_AW-1:0] stride_wb_baseaddr,
  output logic [DATA_W-1:0]  stride_tile_chout,
  output logic [DATA_W-1:0]  stride_feature_chin,
  output logic [DATA_W-1:0]  stride_feature_width,
  output logic [DATA_W-1:0]  stride_feature_height,
  output logic [DATA_W-1:0]  stride_kernel_sizeh,
  output logic [DATA_W-1:0]  stride_kernel_sizew,
  output logic               stride_has_bias,
  output logic               stride_has_relu,
  output logic               conv_complete,
  output logic               cfg_err,
  output instgen_state_e     dbg_state
);

  // Handshake: an instruction transfers on a rising edge where inst_valid && decoder_ready;
  // while inst_valid && !decoder_ready every stride_* output holds its value.

  instgen_state_e     state_q, state_d;
  cfg_t               cfg_q, cfg_d;
  inst_t              inst_q, inst_d, next_inst;
  logic [FRAM_AW-1:0] row_step_q, row_step_d;
  logic [KRAM_AW-1:0] ktile_step_q, ktile_step_d;
  logic               walker_clear, walker_step, last_step;
  logic [DATA_W-1:0]  nxt_ox, nxt_tile_chout;
  logic [FRAM_AW-1:0] nxt_row_base, nxt_wb_cnt;
  logic [KRAM_AW-1:0] nxt_kbase_off;

  conv_pos_walker #(
    .DATA_W(DATA_W), .FRAM_AW(FRAM_AW), .KRAM_AW(KRAM_AW), .COUT_TILE(COUT_TILE)
  ) u_walker (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (walker_clear),
    .step          (walker_step),
    .width         (cfg_q.width),
    .height        (cfg_q.height),
    .ksw           (cfg_q.ksw),
    .ksh           (cfg_q.ksh),
    .sw            (cfg_q.sw),
    .sh            (cfg_q.sh),
    .chout         (cfg_q.chout),
    .row_step      (row_step_q),
    .ktile_step    (ktile_step_q),
    .nxt_ox        (nxt_ox),
    .nxt_row_base  (nxt_row_base),
    .nxt_kbase_off (nxt_kbase_off),
    .nxt_wb_cnt    (nxt_wb_cnt),
    .nxt_tile_chout(nxt_tile_chout),
    .last_step     (last_step)
  );

  always_comb begin
    next_inst                  = '0;
    next_inst.feature_baseaddr = cfg_q.fbase + nxt_row_base + nxt_ox[FRAM_AW-1:0];
    next_inst.kernel_baseaddr  = cfg_q.kbase + nxt_kbase_off;
    next_inst.wb_baseaddr      = cfg_q.wbase + nxt_wb_cnt;
    next_inst.tile_chout       = nxt_tile_chout;
    next_inst.feature_chin     = cfg_q.chin;
    next_inst.feature_width    = cfg_q.width;
    next_inst.feature_height   = cfg_q.height;
    next_inst.kernel_sizeh     = cfg_q.ksh;
    next_inst.kernel_sizew     = cfg_q.ksw;
    next_inst.has_bias         = cfg_q.has_bias;
    next_inst.has_relu         = cfg_q.has_relu;
  end

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    inst_d       = inst_q;
    row_step_d   = row_step_q;
    ktile_step_d = ktile_step_q;
    walker_clear = 1'b0;
    walker_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (csrcmd_valid) begin
          cfg_d.fbase    = feature_baseaddr[BYTE2WORD_SHIFT +: FRAM_AW];
          cfg_d.kbase    = kernel_baseaddr[BYTE2WORD_SHIFT +: KRAM_AW];
          cfg_d.wbase    = wb_baseaddr[BYTE2WORD_SHIFT +: FRAM_AW];
          cfg_d.width    = feature_width;
          cfg_d.height   = feature_height;
          cfg_d.chin     = feature_chin;
          cfg_d.chout    = feature_chout;
          cfg_d.ksw      = kernel_sizew;
          cfg_d.ksh      = kernel_sizeh;
          cfg_d.sw       = stride_w;
          cfg_d.sh       = stride_h;
          cfg_d.has_bias = has_bias;
          cfg_d.has_relu = has_relu;
          state_d        = ST_CHECK;
        end
      end
      ST_CHECK: state_d = cfg_is_bad(cfg_q) ? ST_ERR : ST_PREP;
      ST_PREP: begin
        // Both products are only needed modulo the BRAM address width.
        row_step_d   = cfg_q.sh[FRAM_AW-1:0] * cfg_q.width[FRAM_AW-1:0];
        ktile_step_d = KRAM_AW'(COUT_TILE) * cfg_q.chin[KRAM_AW-1:0] *
                       cfg_q.ksh[KRAM_AW-1:0] * cfg_q.ksw[KRAM_AW-1:0];
        walker_clear = 1'b1;
        inst_d       = next_inst;
        state_d      = ST_EXEC;
      end
      ST_EXEC: begin
        if (decoder_ready) begin
          walker_step = 1'b1;
          inst_d      = next_inst;
          if (last_step) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      inst_q       <= '0;
      row_step_q   <= '0;
      ktile_step_q <= '0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      inst_q       <= inst_d;
      row_step_q   <= row_step_d;
      ktile_step_q <= ktile_step_d;
    end
  end

  assign instgen_ready           = (state_q == ST_IDLE);
  assign inst_valid              = (state_q == ST_EXEC);
  assign conv_complete           = (state_q == ST_DONE);
  assign cfg_err                 = (state_q == ST_ERR);
  assign dbg_state               = state_q;
  assign stride_feature_baseaddr = inst_q.feature_baseaddr;
  assign stride_kernel_baseaddr  = inst_q.kernel_baseaddr;
  assign stride_wb_baseaddr      = inst_q.wb_baseaddr;
  assign stride_tile_chout       = inst_q.tile_chout;
  assign stride_feature_chin     = inst_q.feature_chin;
  assign stride_feature_width    = inst_q.feature_width;
  assign stride_feature_height   = inst_q.feature_height;
  assign stride_kernel_sizeh     = inst_q.kernel_sizeh;
  assign stride_kernel_sizew     = inst_q.kernel_sizew;
  assign stride_has_bias         = inst_q.has_bias;
  assign stride_has_relu         = inst_q.has_relu;

  // Byte-offset and above-window address bits carry no word information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{feature_baseaddr[ADDR_W-1:BYTE2WORD_SHIFT+FRAM_AW],
                              kernel_baseaddr[ADDR_W-1:BYTE2WORD_SHIFT+KRAM_AW],
                              wb_baseaddr[ADDR_W-1:BYTE2WORD_SHIFT+FRAM_AW],
                              feature_baseaddr[BYTE2WORD_SHIFT-1:0],
                              kernel_baseaddr[BYTE2WORD_SHIFT-1:0],
                              wb_baseaddr[BYTE2WORD_SHIFT-1:0]};

endmodule

// File: tb/tb_conv_tile_instgen.sv
// Bench for conv_tile_instgen: table of configs plus random configs, each run
// against an instruction list built from nested position/tile loops.
module tb_conv_tile_instgen;
  import conv_pkg::*;

  localparam int EW = 134;

  logic        clk, rst_n;
  logic        csrcmd_valid, instgen_ready, abort, inst_valid, decoder_ready;
  logic [31:0] feature_baseaddr, kernel_baseaddr, wb_baseaddr;
  logic [31:0] feature_width, feature_height, feature_chin, feature_chout;
  logic [31:0] kernel_sizew, kernel_sizeh, stride_w, stride_h;
  logic        has_bias, has_relu;
  logic [11:0] stride_feature_baseaddr, stride_kernel_baseaddr, stride_wb_baseaddr;
  logic [31:0] stride_tile_chout, stride_feature_chin, stride_feature_width;
  logic [31:0] stride_feature_height, stride_kernel_sizeh, stride_kernel_sizew;
  logic        stride_has_bias, stride_has_relu, conv_complete, cfg_err;
  instgen_state_e dbg_state;

  conv_tile_instgen dut (
    .clk(clk), .rst_n(rst_n), .csrcmd_valid(csrcmd_valid), .instgen_ready(instgen_ready),
    .feature_baseaddr(feature_baseaddr), .kernel_baseaddr(kernel_baseaddr),
    .wb_baseaddr(wb_baseaddr), .feature_width(feature_width),
    .feature_height(feature_height), .feature_chin(feature_chin),
    .feature_chout(feature_chout), .kernel_sizew(kernel_sizew),
    .kernel_sizeh(kernel_sizeh), .stride_w(stride_w), .stride_h(stride_h),
    .has_bias(has_bias), .has_relu(has_relu), .abort(abort),
    .inst_valid(inst_valid), .decoder_ready(decoder_ready),
    .stride_feature_baseaddr(stride_feature_baseaddr),
    .stride_kernel_baseaddr(stride_kernel_baseaddr),
    .stride_wb_baseaddr(stride_wb_baseaddr), .stride_tile_chout(stride_tile_chout),
    .stride_feature_chin(stride_feature_chin), .stride_feature_width(stride_feature_width),
    .stride_feature_height(stride_feature_height), .stride_kernel_sizeh(stride_kernel_sizeh),
    .stride_kernel_sizew(stride_kernel_sizew), .stride_has_bias(stride_has_bias),
    .stride_has_relu(stride_has_relu), .conv_complete(conv_complete), .cfg_err(cfg_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          w, h, kw, kh, sw, sh, cin, cout;
    logic [31:0] fb, kb, wb;
    bit          bias, relu;
    int          exp_n;   // hand-derived instruction count, -1 = not tabulated
  } vec_t;

  logic [EW-1:0] exp_q[$];
  int            obs_feat[$], obs_kern[$], obs_wb[$], obs_ch[$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [31:0] f, k, wbw, ch, cin,
                                         input logic [31:0] wd, ht, ksh, ksw,
                                         input logic b, r);
    return {f[11:0], k[11:0], wbw[11:0], ch, cin, wd[7:0], ht[7:0], ksh[7:0], ksw[7:0], b, r};
  endfunction

  // ---------------- reference model ----------------
  function automatic bit model_build(input vec_t v);
    bit err;
    int n, t, ch;
    logic [31:0] f, k, wbw;
    err = (v.sw == 0) || (v.sh == 0) || (v.kw == 0) || (v.kh == 0) || (v.cin == 0) ||
          (v.cout == 0) || (v.kw > v.w) || (v.kh > v.h);
    if (err) return 1'b1;
    n = 0;
    for (t = 0; t * 4 < v.cout; t++) begin
      ch = (v.cout - 4 * t > 4) ? 4 : v.cout - 4 * t;
      for (int oy = 0; oy + v.kh <= v.h; oy += v.sh)
        for (int ox = 0; ox + v.kw <= v.w; ox += v.sw) begin
          f   = ((v.fb >> 2) + oy * v.w + ox) % 4096;
          k   = ((v.kb >> 2) + t * 4 * v.cin * v.kh * v.kw) % 4096;
          wbw = ((v.wb >> 2) + n) % 4096;
          exp_q.push_back(pack(f, k, wbw, ch, v.cin, v.w, v.h, v.kh, v.kw, v.bias, v.relu));
          n++;
        end
    end
    return 1'b0;
  endfunction

  function automatic logic [EW-1:0] dut_inst();
    return pack({20'd0, stride_feature_baseaddr}, {20'd0, stride_kernel_baseaddr},
                {20'd0, stride_wb_baseaddr}, stride_tile_chout, stride_feature_chin,
                stride_feature_width, stride_feature_height, stride_kernel_sizeh,
                stride_kernel_sizew, stride_has_bias, stride_has_relu);
  endfunction

  // ---------------- driver + scoreboard ----------------
  task automatic run_vec(input vec_t v, input int rdy_pct, input int abort_at);
    bit err, fin, stalled, abort_now;
    int cyc, first, last_hs, issued;
    logic [EW-1:0] cur, prev, expv;
    exp_q.delete(); obs_feat.delete(); obs_kern.delete(); obs_wb.delete(); obs_ch.delete();
    err = model_build(v);
    chk("ready_before_accept", {159'd0, instgen_ready}, 160'd1);
    feature_baseaddr = v.fb; kernel_baseaddr = v.kb; wb_baseaddr = v.wb;
    feature_width = v.w; feature_height = v.h; feature_chin = v.cin; feature_chout = v.cout;
    kernel_sizew = v.kw; kernel_sizeh = v.kh; stride_w = v.sw; stride_h = v.sh;
    has_bias = v.bias; has_relu = v.relu; csrcmd_valid = 1'b1;
    @(negedge clk);
    csrcmd_valid = 1'b0;
    // Scramble the CSR bus: the run must use only the latched copy.
    feature_baseaddr = $urandom; feature_width = $urandom_range(1, 50);
    feature_chout = $urandom_range(1, 50); stride_w = $urandom_range(0, 5);
    cyc = 1; first = -1; last_hs = -1; issued = 0; stalled = 0; fin = 0; prev = '0;
    while (!fin && cyc < 4000) begin
      cur = dut_inst();
      if (inst_valid) begin
        if (first < 0) first = cyc;
        if (stalled) chk("stall_stable", {26'd0, cur}, {26'd0, prev});
      end
      if (conv_complete) begin
        chk("complete_after_last", cyc, last_hs + 1);
        chk("complete_queue_empty", exp_q.size(), 0);
        fin = 1;
      end else if (cfg_err) begin
        chk("cfg_err_latency", cyc, 2);
        fin = 1;
      end else begin
        abort_now     = (abort_at >= 0) && (issued == abort_at) && inst_valid;
        decoder_ready = abort_now ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
        abort         = abort_now;
        csrcmd_valid  = inst_valid ? 1'($urandom_range(0, 1)) : 1'b0;
        if (inst_valid && decoder_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_inst", {26'd0, cur}, 160'd0);
          end else begin
            expv = exp_q.pop_front();
            chk("inst_fields", {26'd0, cur}, {26'd0, expv});
          end
          obs_feat.push_back(int'(stride_feature_baseaddr));
          obs_kern.push_back(int'(stride_kernel_baseaddr));
          obs_wb.push_back(int'(stride_wb_baseaddr));
          obs_ch.push_back(int'(stride_tile_chout));
          issued++; last_hs = cyc;
        end
        stalled = inst_valid && !decoder_ready;
        prev = cur;
        @(negedge clk);
        cyc++;
        if (abort_now) begin
          abort = 1'b0;
          chk("abort_valid_low", {159'd0, inst_valid}, 160'd0);
          chk("abort_ready_high", {159'd0, instgen_ready}, 160'd1);
          fin = 1;
        end
      end
    end
    if (!fin) begin
      errors++; checks++;
      $display("FAIL run_timeout: got no completion after %0d cycles, required one", cyc);
    end
    csrcmd_valid = 1'b0; decoder_ready = 1'b0; abort = 1'b0;
    if (err) chk("err_no_inst", first, -1);
    else if (abort_at < 0) chk("first_inst_latency", first, 3);
    if (v.exp_n >= 0 && abort_at < 0) chk("inst_count", issued, v.exp_n);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_no_pulse", {158'd0, conv_complete, cfg_err}, 160'd0);
      chk("post_ready", {159'd0, instgen_ready}, 160'd1);
    end
  endtask

  vec_t vt[8];
  vec_t rv;
  int   t1_feat[4] = '{'h40, 'h41, 'h44, 'h45};
  int   t2_feat[6] = '{0, 2, 4, 18, 20, 22};
  int   t3_kern[3] = '{0, 72, 144};
  int   t3_ch[3]   = '{4, 4, 2};

  initial begin
    //            w  h kw kh sw sh cin cout  fb       kb       wb      bias relu n
    vt[0] = '{4, 4, 3, 3, 1, 1, 1, 1,  32'h100, 32'h0,   32'h200, 1'b1, 1'b0, 4};
    vt[1] = '{6, 5, 2, 2, 2, 3, 1, 1,  32'h0,   32'h40,  32'h300, 1'b0, 1'b1, 6};
    vt[2] = '{4, 4, 3, 3, 1, 1, 2, 10, 32'h0,   32'h0,   32'h10,  1'b1, 1'b1, 12};
    vt[3] = '{4, 4, 3, 3, 0, 1, 1, 1,  32'h100, 32'h0,   32'h200, 1'b0, 1'b0, 0};
    vt[4] = '{4, 4, 5, 3, 1, 1, 1, 1,  32'h100, 32'h0,   32'h200, 1'b0, 1'b0, 0};
    vt[5] = '{4, 2, 3, 3, 1, 1, 1, 1,  32'h100, 32'h0,   32'h200, 1'b0, 1'b0, 0};
    vt[6] = '{4, 4, 3, 3, 1, 1, 1, 0,  32'h100, 32'h0,   32'h200, 1'b0, 1'b0, 0};
    vt[7] = '{3, 3, 3, 3, 2, 2, 3, 4,  32'h8,   32'hC,   32'h4,   1'b1, 1'b0, 1};

    rst_n = 1'b0; csrcmd_valid = 1'b0; abort = 1'b0; decoder_ready = 1'b0;
    feature_baseaddr = '0; kernel_baseaddr = '0; wb_baseaddr = '0;
    feature_width = '0; feature_height = '0; feature_chin = '0; feature_chout = '0;
    kernel_sizew = '0; kernel_sizeh = '0; stride_w = '0; stride_h = '0;
    has_bias = 1'b0; has_relu = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready", {159'd0, instgen_ready}, 160'd1);
    chk("reset_flags", {157'd0, inst_valid, conv_complete, cfg_err}, 160'd0);
    chk("reset_state", {157'd0, dbg_state}, {157'd0, ST_IDLE});
    chk("reset_inst", {26'd0, dut_inst()}, 160'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vt[i], (i == 0) ? 100 : 60, -1);
      if (i == 0)
        for (int j = 0; j < 4; j++) begin
          chk("t1_feature", obs_feat[j], t1_feat[j]);
          chk("t1_wb", obs_wb[j], 'h80 + j);
        end
      if (i == 1)
        for (int j = 0; j < 6; j++) chk("t2_feature", obs_feat[j], t2_feat[j]);
      if (i == 2)
        for (int j = 0; j < 3; j++) begin
          chk("t3_kernel", obs_kern[4 * j], t3_kern[j]);
          chk("t3_chout", obs_ch[4 * j], t3_ch[j]);
        end
    end

    // Abort during EXEC after 2 instructions, then a clean rerun.
    run_vec(vt[0], 100, 2);
    run_vec(vt[0], 100, -1);
    for (int j = 0; j < 4; j++) chk("rerun_feature", obs_feat[j], t1_feat[j]);

    // Abort in IDLE beats a simultaneous config request.
    csrcmd_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    csrcmd_valid = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_abort_ready", {159'd0, instgen_ready}, 160'd1);
    chk("idle_abort_no_valid", {159'd0, inst_valid}, 160'd0);

    for (int r = 0; r < 12; r++) begin
      rv.w = $urandom_range(1, 9);   rv.h = $urandom_range(1, 9);
      rv.kw = $urandom_range(1, rv.w); rv.kh = $urandom_range(1, rv.h);
      rv.sw = $urandom_range(0, 3);  rv.sh = $urandom_range(1, 3);
      rv.cin = $urandom_range(1, 6); rv.cout = $urandom_range(1, 11);
      rv.fb = $urandom; rv.kb = $urandom; rv.wb = $urandom;
      rv.bias = 1'($urandom_range(0, 1)); rv.relu = 1'($urandom_range(0, 1));
      rv.exp_n = -1;
      run_vec(rv, $urandom_range(30, 100), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
